// File: rtl/gate_pkg.sv
// Shared gate-mode encodings and the N-input reduction used by filtered_gate.
package gate_pkg;
  localparam logic [1:0] MODE_AND  = 2'b00;
  localparam logic [1:0] MODE_OR   = 2'b01;
  localparam logic [1:0] MODE_XOR  = 2'b10;
  localparam logic [1:0] MODE_NAND = 2'b11;

  // Widest input vector the reduction accepts; callers zero-extend into it.
  localparam int GATE_MAX_IN = 64;

  // Only the low n bits take part, so the padding never disturbs AND/NAND.
  function automatic logic gate_reduce(input logic [GATE_MAX_IN-1:0] v,
                                       input int n,
                                       input logic [1:0] mode);
    logic a, o, x, r;
    a = 1'b1;
    o = 1'b0;
    x = 1'b0;
    for (int i = 0; i < GATE_MAX_IN; i++) begin
      if (i < n) begin
        a = a & v[i];
        o = o | v[i];
        x = x ^ v[i];
      end
    end
    case (mode)
      MODE_AND: r = a;
      MODE_OR:  r = o;
      MODE_XOR: r = x;
      default:  r = ~a;
    endcase
    return r;
  endfunction
endpackage

// File: rtl/filtered_gate_if.sv
// Input/output bundle of filtered_gate; master drives inputs, slave is the gate.
interface filtered_gate_if #(
  parameter int N_IN  = 2,
  parameter int CNT_W = 8
);
  logic [N_IN-1:0]  in_i;
  logic [1:0]       mode_i;
  logic             clr_i;
  logic             comb_o;
  logic             q_o;
  logic             rise_o;
  logic             fall_o;
  logic [CNT_W-1:0] evt_cnt_o;

  modport master (
    output in_i, mode_i, clr_i,
    input  comb_o, q_o, rise_o, fall_o, evt_cnt_o
  );

  modport slave (
    input  in_i, mode_i, clr_i,
    output comb_o, q_o, rise_o, fall_o, evt_cnt_o
  );
endinterface

// File: rtl/filtered_gate_stable_filter.sv
// Debounce: d_i must differ from q_o for STABLE_CYCLES sampled edges before q_o follows.
module stable_filter #(
  parameter int STABLE_CYCLES = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o,
  output logic chg_o
);
  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);

  logic          s_q, q_q, rise_q, fall_q;
  logic [CW-1:0] cnt_q;

  // High on the edge where q_o is about to flip; lets the event counter act in step.
  assign chg_o  = (s_q != q_q) && (cnt_q == LAST);
  assign q_o    = q_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_q    <= 1'b0;
      q_q    <= 1'b0;
      cnt_q  <= '0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      s_q    <= d_i;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
      if (s_q == q_q) begin
        cnt_q <= '0;
      end else if (cnt_q == LAST) begin
        q_q    <= s_q;
        cnt_q  <= '0;
        rise_q <= s_q;
        fall_q <= ~s_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule

// File: rtl/filtered_gate.sv
// N-input selectable gate with raw output, debounced output, edge pulses and event counter.
module filtered_gate
  import gate_pkg::*;
#(
  parameter int N_IN          = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  filtered_gate_if.slave  bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic                   raw;
  logic                   chg;
  logic [GATE_MAX_IN-1:0] in_ext;
  logic [CNT_W-1:0]       evt_cnt_q, evt_cnt_d;

  // N_IN must not exceed GATE_MAX_IN.
  assign in_ext     = GATE_MAX_IN'(bus.in_i);
  assign raw        = gate_reduce(in_ext, N_IN, bus.mode_i);
  assign bus.comb_o = raw;

  stable_filter #(.STABLE_CYCLES(STABLE_CYCLES)) u_filt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (raw),
    .q_o    (bus.q_o),
    .rise_o (bus.rise_o),
    .fall_o (bus.fall_o),
    .chg_o  (chg)
  );

  // Clear wins over a coincident transition; that transition is simply not counted.
  always_comb begin
    evt_cnt_d = evt_cnt_q;
    if (bus.clr_i)                          evt_cnt_d = '0;
    else if (chg && evt_cnt_q != CNT_MAX)   evt_cnt_d = evt_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) evt_cnt_q <= '0;
    else         evt_cnt_q <= evt_cnt_d;
  end

  assign bus.evt_cnt_o = evt_cnt_q;
endmodule

// File: tb/tb_filtered_gate.sv
// Bench for filtered_gate: three configurations against a history-window reference model.
module tb_filtered_gate;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  filtered_gate_if #(.N_IN(2), .CNT_W(8)) if0 ();
  filtered_gate_if #(.N_IN(2), .CNT_W(2)) if1 ();
  filtered_gate_if #(.N_IN(5), .CNT_W(8)) if2 ();

  filtered_gate #(.N_IN(2), .STABLE_CYCLES(4), .CNT_W(8)) u0 (.clk_i(clk), .rst_ni(rst_n), .bus(if0));
  filtered_gate #(.N_IN(2), .STABLE_CYCLES(4), .CNT_W(2)) u1 (.clk_i(clk), .rst_ni(rst_n), .bus(if1));
  filtered_gate #(.N_IN(5), .STABLE_CYCLES(1), .CNT_W(8)) u2 (.clk_i(clk), .rst_ni(rst_n), .bus(if2));

  logic [4:0] in_v [3];
  logic [1:0] mode_v [3];
  logic       clr_v [3];

  assign if0.in_i = in_v[0][1:0];  assign if0.mode_i = mode_v[0];  assign if0.clr_i = clr_v[0];
  assign if1.in_i = in_v[1][1:0];  assign if1.mode_i = mode_v[1];  assign if1.clr_i = clr_v[1];
  assign if2.in_i = in_v[2];       assign if2.mode_i = mode_v[2];  assign if2.clr_i = clr_v[2];

  localparam int S_A  [3] = '{4, 4, 1};
  localparam int N_A  [3] = '{2, 2, 5};
  localparam int CMAX [3] = '{255, 3, 255};

  // Model: q flips once the last S sampled raw values all disagree with it.
  logic        m_q [3], m_r [3], m_f [3];
  int          m_cnt [3];
  logic [31:0] hist [3];
  int          hlen [3];

  function automatic logic ref_gate(input logic [4:0] v, input int n, input logic [1:0] m);
    int ones = 0;
    for (int i = 0; i < n; i++) ones += int'(v[i]);
    case (m)
      2'b00:   return ones == n;
      2'b01:   return ones > 0;
      2'b10:   return (ones % 2) == 1;
      default: return ones != n;
    endcase
  endfunction

  function automatic logic [11:0] exp_v(input int k);
    return {ref_gate(in_v[k], N_A[k], mode_v[k]), m_q[k], m_r[k], m_f[k], 8'(m_cnt[k])};
  endfunction

  function automatic logic [11:0] obs(input int k);
    case (k)
      0:       return {if0.comb_o, if0.q_o, if0.rise_o, if0.fall_o, if0.evt_cnt_o};
      1:       return {if1.comb_o, if1.q_o, if1.rise_o, if1.fall_o, 6'd0, if1.evt_cnt_o};
      default: return {if2.comb_o, if2.q_o, if2.rise_o, if2.fall_o, if2.evt_cnt_o};
    endcase
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_q[k] = 1'b0; m_r[k] = 1'b0; m_f[k] = 1'b0; m_cnt[k] = 0;
      hist[k] = '0; hlen[k] = 1;
    end
  endtask

  task automatic tick();
    logic r [3];
    logic c [3];
    logic chg;
    for (int k = 0; k < 3; k++) begin
      r[k] = ref_gate(in_v[k], N_A[k], mode_v[k]);
      c[k] = clr_v[k];
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      chg = (hlen[k] >= S_A[k]);
      for (int i = 0; i < S_A[k]; i++) if (hist[k][i] == m_q[k]) chg = 1'b0;
      m_r[k] = chg && !m_q[k];
      m_f[k] = chg && m_q[k];
      if (chg) m_q[k] = !m_q[k];
      if (c[k]) m_cnt[k] = 0;
      else if (chg && m_cnt[k] < CMAX[k]) m_cnt[k]++;
      hist[k] = {hist[k][30:0], r[k]};
      if (hlen[k] < 31) hlen[k]++;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      in_v[k] = '0; mode_v[k] = 2'b00; clr_v[k] = 1'b0;
    end
    model_reset();
    #12;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs(k) !== 12'h000) begin
        failures++; $display("FAIL reset dut%0d got=%h exp=000", k, obs(k));
      end
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_and();
    in_v[0] = 5'b00011;
    #1;
    checks++;
    if (if0.comb_o !== 1'b1) begin failures++; $display("FAIL and_comb got=%b exp=1", if0.comb_o); end
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (obs(0) !== exp_v(0)) begin
        failures++; $display("FAIL and_edge%0d got=%h exp=%h", e, obs(0), exp_v(0));
      end
      if (e == 4 || e == 5 || e == 6) begin
        checks++;
        if ({if0.q_o, if0.rise_o, if0.evt_cnt_o} !== (e == 4 ? 10'h000 : e == 5 ? 10'h301 : 10'h201)) begin
          failures++; $display("FAIL and_const%0d got q=%b rise=%b cnt=%0d", e, if0.q_o, if0.rise_o, if0.evt_cnt_o);
        end
      end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] cnt0;
    mode_v[0] = 2'b01; in_v[0] = 5'b00000;
    for (int e = 0; e < 10; e++) tick();
    cnt0 = if0.evt_cnt_o;
    in_v[0] = 5'b00001;
    #1;
    checks++;
    if (if0.comb_o !== 1'b1) begin failures++; $display("FAIL glitch_comb got=%b exp=1", if0.comb_o); end
    for (int e = 0; e < 11; e++) begin
      if (e == 3) in_v[0] = 5'b00000;
      tick();
      checks++;
      if (obs(0) !== exp_v(0) || if0.q_o !== 1'b0 || if0.rise_o !== 1'b0 || if0.evt_cnt_o !== cnt0) begin
        failures++; $display("FAIL glitch_cyc%0d got=%h exp=%h", e, obs(0), exp_v(0));
      end
    end
  endtask

  task automatic test_mode_sweep();
    logic [3:0] qseq;
    int rises = 0, falls = 0;
    in_v[0] = 5'b00010;
    for (int m = 0; m < 4; m++) begin
      mode_v[0] = 2'(m);
      for (int e = 0; e < 10; e++) begin
        tick();
        rises += int'(if0.rise_o);
        falls += int'(if0.fall_o);
        checks++;
        if (obs(0) !== exp_v(0)) begin
          failures++; $display("FAIL sweep_m%0d_cyc%0d got=%h exp=%h", m, e, obs(0), exp_v(0));
        end
      end
      qseq[3-m] = if0.q_o;
    end
    checks++;
    if (qseq !== 4'b0111 || rises != 1 || falls != 0) begin
      failures++; $display("FAIL sweep_seq got=%b rises=%0d falls=%0d exp=0111 1 0", qseq, rises, falls);
    end
  endtask

  task automatic test_saturation();
    for (int t = 0; t < 6; t++) begin
      in_v[1] = (t % 2 == 0) ? 5'b00011 : 5'b00000;
      for (int e = 0; e < 8; e++) begin
        tick();
        checks++;
        if (obs(1) !== exp_v(1)) begin
          failures++; $display("FAIL sat_t%0d_cyc%0d got=%h exp=%h", t, e, obs(1), exp_v(1));
        end
      end
    end
    checks++;
    if (if1.evt_cnt_o !== 2'd3) begin failures++; $display("FAIL sat_hold got=%0d exp=3", if1.evt_cnt_o); end
    in_v[1] = 5'b00011;
    for (int e = 0; e < 4; e++) tick();
    clr_v[1] = 1'b1;
    tick();
    clr_v[1] = 1'b0;
    checks++;
    if ({if1.q_o, if1.rise_o, if1.evt_cnt_o} !== 4'b1100 || obs(1) !== exp_v(1)) begin
      failures++; $display("FAIL sat_clr got q=%b rise=%b cnt=%0d exp q=1 rise=1 cnt=0", if1.q_o, if1.rise_o, if1.evt_cnt_o);
    end
    tick();
    checks++;
    if (if1.evt_cnt_o !== 2'd0) begin failures++; $display("FAIL sat_after_clr got=%0d exp=0", if1.evt_cnt_o); end
  endtask

  task automatic test_reset_mid();
    mode_v[0] = 2'b00; in_v[0] = 5'b00000;
    for (int e = 0; e < 8; e++) tick();
    in_v[0] = 5'b00011;
    for (int e = 0; e < 3; e++) tick();
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs(0) !== 12'h800) begin failures++; $display("FAIL rstmid_async got=%h exp=800", obs(0)); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      tick();
      checks++;
      if (obs(0) !== exp_v(0) || if0.q_o !== (e >= 5)) begin
        failures++; $display("FAIL rstmid_edge%0d got=%h exp=%h", e, obs(0), exp_v(0));
      end
    end
  endtask

  task automatic test_xor5();
    mode_v[2] = 2'b10; in_v[2] = 5'b10110;
    #1;
    checks++;
    if (if2.comb_o !== 1'b1) begin failures++; $display("FAIL xor5_comb got=%b exp=1", if2.comb_o); end
    for (int e = 1; e <= 2; e++) begin
      tick();
      checks++;
      if (obs(2) !== exp_v(2) || {if2.q_o, if2.rise_o} !== (e == 2 ? 2'b11 : 2'b00)) begin
        failures++; $display("FAIL xor5_rise_edge%0d got=%h exp=%h", e, obs(2), exp_v(2));
      end
    end
    in_v[2] = 5'b10111;
    for (int e = 1; e <= 2; e++) begin
      tick();
      checks++;
      if (obs(2) !== exp_v(2) || {if2.q_o, if2.fall_o} !== (e == 2 ? 2'b01 : 2'b10)) begin
        failures++; $display("FAIL xor5_fall_edge%0d got=%h exp=%h", e, obs(2), exp_v(2));
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 3) == 0) in_v[k] = 5'($urandom);
        if ($urandom_range(0, 15) == 0) mode_v[k] = 2'($urandom);
        clr_v[k] = ($urandom_range(0, 19) == 0);
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs(k) !== exp_v(k)) begin
          failures++; $display("FAIL rand_c%0d_dut%0d got=%h exp=%h", c, k, obs(k), exp_v(k));
        end
      end
    end
    for (int k = 0; k < 3; k++) clr_v[k] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_and();
    test_glitch();
    test_mode_sweep();
    test_saturation();
    test_reset_mid();
    test_xor5();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
